fifo_drain_accumulator: RTL and testbench

// - Read-side consumer of the multiplier-to-accumulator async FIFO; runs entirely in the Rclk domain.
// - Watches the FIFO empty flag and pulses the read enable to drain one 8-bit product per cycle.
// - Sums COUNT consecutive products into one block sum.
// - Presents each block sum on a valid/ready output handshake.

---
 rtl/fifo_drain_accumulator.sv | 114 +++++++++++
 tb/tb_fifo_drain_accumulator.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_accumulator.sv
// fifo_drain_accumulator
//   Read-side consumer of the multiplier-to-accumulator async FIFO, running
//   entirely in the Rclk domain. It drains one product per cycle while the
//   FIFO is non-empty, sums COUNT consecutive products into a block sum, and
//   offers each block sum on a valid/ready handshake.
//
// Ports
//   Rclk       read-domain clock
//   rrst       asynchronous active-high reset
//   en         1 = run blocks back to back, 0 = stop after the current block
//   clear      synchronous abort to IDLE; drops the partial sum and ovf
//   Rempty_i   FIFO empty flag (Rclk domain)
//   Acc_i      FIFO head data, valid while Rempty_i is low
//   ren_o      FIFO read enable; the head is consumed on an edge with ren_o=1
//   sum_o      completed block sum, stable while sum_valid is high
//   sum_valid  block sum available
//   sum_ready  downstream accepts sum_o
//   busy       high in ACCUM or DONE
//   ovf        sticky wrap flag for the accumulator adds
module fifo_drain_accumulator #(
    parameter int DATA_W = 8,
    parameter int COUNT  = 4,
    parameter int SUM_W  = 16
) (
    input  logic              Rclk,
    input  logic              rrst,
    input  logic              en,
    input  logic              clear,
    input  logic              Rempty_i,
    input  logic [DATA_W-1:0] Acc_i,
    output logic              ren_o,
    output logic [SUM_W-1:0]  sum_o,
    output logic              sum_valid,
    input  logic              sum_ready,
    output logic              busy,
    output logic              ovf
);

    localparam int               CNT_W    = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [SUM_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [SUM_W:0]   add_full;

    // Read enable reacts to the empty flag in the same cycle; clear has to
    // suppress it so an aborting edge never consumes a product.
    assign ren_o    = (state == ACCUM) && !Rempty_i && !clear;
    assign busy     = (state != IDLE);
    // One extra bit captures the carry out of the SUM_W-wide add.
    assign add_full = {1'b0, acc} + (SUM_W + 1)'(Acc_i);

    always_ff @(posedge Rclk or posedge rrst) begin
        if (rrst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            sum_o     <= '0;
            sum_valid <= 1'b0;
            ovf       <= 1'b0;
        end else if (clear) begin
            // sum_o intentionally keeps its last value
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            sum_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        state <= ACCUM;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                ACCUM: begin
                    if (ren_o) begin
                        acc <= add_full[SUM_W-1:0];
                        if (add_full[SUM_W]) begin
                            ovf <= 1'b1;
                        end
                        if (cnt == CNT_LAST) begin
                            // The closing read's product is part of the sum.
                            sum_o     <= add_full[SUM_W-1:0];
                            sum_valid <= 1'b1;
                            cnt       <= '0;
                            state     <= DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (sum_valid && sum_ready) begin
                        sum_valid <= 1'b0;
                        acc       <= '0;
                        cnt       <= '0;
                        state     <= en ? ACCUM : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_drain_accumulator.sv
// tb_fifo_drain_accumulator
//   Two instances share all inputs: the default 16-bit accumulator and a
//   9-bit one that wraps easily. A FIFO model feeds both; a monitor turns the
//   observed reads into expected block sums (plain arithmetic on the product
//   stream) and checks them when a handshake happens.
module tb_fifo_drain_accumulator;

    localparam int COUNT = 4;

    typedef struct {
        logic [15:0] s16;
        logic [8:0]  s9;
        logic        o16;
        logic        o9;
    } exp_t;

    logic        Rclk      = 1'b0;
    logic        rrst      = 1'b1;
    logic        en        = 1'b0;
    logic        clear     = 1'b0;
    logic        sum_ready = 1'b0;
    logic        gap_on    = 1'b0;
    logic        Rempty_i  = 1'b1;
    logic [7:0]  Acc_i     = '0;
    logic        ren_o, sum_valid, busy, ovf;
    logic [15:0] sum_o;
    logic        ren9, sv9, busy9, ovf9;
    logic [8:0]  sum9;

    // FIFO model: src[n_read .. n_loaded-1] is the content
    logic [7:0]  src [0:4095];
    int unsigned n_loaded = 0;
    int unsigned n_read   = 0;

    int unsigned n_chk = 0, n_fail = 0;
    int unsigned cyc = 0, rd_total = 0, hs_total = 0, sv_cnt = 0;
    int unsigned rd_cyc[$];
    int unsigned hs_cyc[$];
    exp_t        exp_q[$];
    int unsigned blk_n = 0, blk_sum = 0;
    logic        ovf16_m = 1'b0, ovf9_m = 1'b0;

    fifo_drain_accumulator #(.DATA_W(8), .COUNT(COUNT), .SUM_W(16)) u_dut (
        .Rclk(Rclk), .rrst(rrst), .en(en), .clear(clear), .Rempty_i(Rempty_i),
        .Acc_i(Acc_i), .ren_o(ren_o), .sum_o(sum_o), .sum_valid(sum_valid),
        .sum_ready(sum_ready), .busy(busy), .ovf(ovf)
    );

    fifo_drain_accumulator #(.DATA_W(8), .COUNT(COUNT), .SUM_W(9)) u_w9 (
        .Rclk(Rclk), .rrst(rrst), .en(en), .clear(clear), .Rempty_i(Rempty_i),
        .Acc_i(Acc_i), .ren_o(ren9), .sum_o(sum9), .sum_valid(sv9),
        .sum_ready(sum_ready), .busy(busy9), .ovf(ovf9)
    );

    initial forever #5 Rclk = ~Rclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic refresh();
        Rempty_i = gap_on || (n_read == n_loaded);
        Acc_i    = (n_read < n_loaded) ? src[n_read] : 8'h00;
    endtask

    // Monitor / scoreboard: samples 3 time units after the falling edge,
    // updates the FIFO just after the rising edge.
    initial begin : monitor
        logic        s_ren, s_ren9, s_emp, s_sv, s_sv9, s_sr, s_cl, s_rst, s_busy, s_ovf, s_ovf9;
        logic [7:0]  s_d;
        logic [15:0] s_sum;
        logic [8:0]  s_sum9;
        logic        p_hold;
        logic [15:0] p_sum;
        exp_t        e;
        p_hold = 1'b0;
        p_sum  = '0;
        forever begin
            @(negedge Rclk);
            #1 refresh();
            #2;
            cyc++;
            s_ren = ren_o;  s_ren9 = ren9;  s_emp = Rempty_i; s_d = Acc_i;
            s_sv = sum_valid; s_sv9 = sv9; s_sr = sum_ready; s_cl = clear;
            s_rst = rrst; s_busy = busy; s_sum = sum_o; s_sum9 = sum9;
            s_ovf = ovf; s_ovf9 = ovf9;
            if (!s_rst) begin
                if (s_emp) begin
                    check("ren_while_empty", s_ren, 0);
                    check("ren9_while_empty", s_ren9, 0);
                end
                if (s_sv) check("ren_while_pending", s_ren, 0);
                if (s_cl) check("ren_during_clear", s_ren, 0);
                if (s_ren || s_sv) check("busy_when_active", s_busy, 1);
                if (p_hold) begin
                    check("sum_valid_held", s_sv, 1);
                    check("sum_o_held", s_sum, p_sum);
                end
                if (s_sv) sv_cnt++;
            end
            if (s_rst || s_cl) begin
                blk_n = 0; blk_sum = 0; ovf16_m = 1'b0; ovf9_m = 1'b0;
                exp_q.delete();
            end else begin
                if (s_sv && s_sr) begin
                    hs_total++;
                    hs_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        check("sum_without_block", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("sum_o", s_sum, e.s16);
                        check("sum_o_w9", s_sum9, e.s9);
                        check("ovf", s_ovf, e.o16);
                        check("ovf_w9", s_ovf9, e.o9);
                        check("sum_valid_w9", s_sv9, 1);
                    end
                end
                if (s_ren) begin
                    rd_total++;
                    rd_cyc.push_back(cyc);
                    blk_sum += s_d;
                    blk_n++;
                    if (blk_n == COUNT) begin
                        if (blk_sum >= 65536) ovf16_m = 1'b1;
                        if (blk_sum >= 512)   ovf9_m  = 1'b1;
                        e.s16 = 16'(blk_sum % 65536);
                        e.s9  = 9'(blk_sum % 512);
                        e.o16 = ovf16_m;
                        e.o9  = ovf9_m;
                        exp_q.push_back(e);
                        blk_n = 0;
                        blk_sum = 0;
                    end
                end
            end
            p_hold = s_sv && !s_sr && !s_cl && !s_rst;
            p_sum  = s_sum;
            @(posedge Rclk);
            #1;
            if (s_ren && !s_rst) n_read++;
            refresh();
        end
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge Rclk);
    endtask

    task automatic push(input logic [7:0] d);
        if (n_loaded < 4096) begin
            src[n_loaded] = d;
            n_loaded++;
        end
    endtask

    task automatic do_reset();
        @(negedge Rclk);
        rrst = 1'b1; en = 1'b0; clear = 1'b0; gap_on = 1'b0;
        tick(2);
        rrst = 1'b0;
        tick(1);
    endtask

    task automatic wait_reads(input int unsigned target, input int unsigned limit);
        int unsigned n = 0;
        while (rd_total < target && n < limit) begin
            @(negedge Rclk);
            n++;
        end
        if (rd_total < target) check("wait_reads_timeout", rd_total, target);
    endtask

    task automatic wait_hs(input int unsigned target, input int unsigned limit);
        int unsigned n = 0;
        while (hs_total < target && n < limit) begin
            @(negedge Rclk);
            n++;
        end
        if (hs_total < target) check("wait_hs_timeout", hs_total, target);
    endtask

    task automatic wait_sv(input int unsigned limit);
        int unsigned n = 0;
        while (!sum_valid && n < limit) begin
            @(negedge Rclk);
            n++;
        end
        if (!sum_valid) check("wait_sv_timeout", sum_valid, 1);
    endtask

    initial begin : stimulus
        int unsigned b_rd, b_hs, b_sv, r0;
        logic [7:0] d;

        // Reset values
        do_reset();
        check("rst_ren_o", ren_o, 0);
        check("rst_sum_o", sum_o, 0);
        check("rst_sum_valid", sum_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf, 0);
        check("rst_sum_o_w9", sum9, 0);
        check("rst_ovf_w9", ovf9, 0);

        // Two back-to-back blocks of 3,5,7,9 with ready held high
        b_rd = rd_cyc.size(); b_hs = hs_cyc.size(); b_sv = sv_cnt;
        sum_ready = 1'b1;
        push(3); push(5); push(7); push(9); push(3); push(5); push(7); push(9);
        en = 1'b1;
        wait_hs(hs_total + 2, 60);
        tick(2);
        en = 1'b0;
        check("t1_reads", rd_cyc.size() - b_rd, 8);
        check("t1_sv_cycles", sv_cnt - b_sv, 2);
        if (rd_cyc.size() >= b_rd + 8 && hs_cyc.size() >= b_hs + 2) begin
            for (int i = 1; i < 4; i++) begin
                check("t1_b1_back_to_back", rd_cyc[b_rd+i], rd_cyc[b_rd] + i);
                check("t1_b2_back_to_back", rd_cyc[b_rd+4+i], rd_cyc[b_rd+4] + i);
            end
            check("t1_sv_latency", hs_cyc[b_hs], rd_cyc[b_rd+3] + 1);
            check("t1_next_block_start", rd_cyc[b_rd+4], hs_cyc[b_hs] + 1);
        end

        // Three empty cycles between the 2nd and 3rd products
        do_reset();
        b_rd = rd_cyc.size(); b_hs = hs_cyc.size();
        push(3); push(5); push(7); push(9);
        en = 1'b1;
        wait_reads(rd_total + 2, 30);
        gap_on = 1'b1;
        tick(3);
        gap_on = 1'b0;
        wait_hs(hs_total + 1, 30);
        en = 1'b0;
        tick(2);
        if (rd_cyc.size() >= b_rd + 4 && hs_cyc.size() >= b_hs + 1) begin
            check("t2_gap_len", rd_cyc[b_rd+2], rd_cyc[b_rd+1] + 4);
            check("t2_resume", rd_cyc[b_rd+3], rd_cyc[b_rd+2] + 1);
            check("t2_done", hs_cyc[b_hs], rd_cyc[b_rd+3] + 1);
        end

        // Downstream stalls for 5 cycles with a non-empty FIFO
        do_reset();
        sum_ready = 1'b0;
        push(3); push(5); push(7); push(9); push(1); push(1); push(1); push(1);
        en = 1'b1;
        wait_sv(30);
        r0 = rd_total;
        b_hs = hs_total;
        tick(5);
        check("t3_no_reads_pending", rd_total, r0);
        check("t3_sv_held", sum_valid, 1);
        check("t3_sum_held", sum_o, 24);
        check("t3_fifo_nonempty", n_loaded - n_read, 4);
        sum_ready = 1'b1;
        tick(1);
        sum_ready = 1'b0;
        check("t3_one_handshake", hs_total, b_hs + 1);
        tick(3);
        check("t3_still_one", hs_total, b_hs + 1);
        check("t3_sv_dropped", sum_valid, 0);
        sum_ready = 1'b1;
        wait_hs(b_hs + 2, 30);
        en = 1'b0;
        tick(2);

        // Wrap in the 9-bit instance, then clear
        do_reset();
        sum_ready = 1'b1;
        push(255); push(255); push(255); push(255);
        en = 1'b1;
        wait_hs(hs_total + 1, 30);
        en = 1'b0;
        tick(2);
        check("t4_ovf_w9_sticky", ovf9, 1);
        check("t4_ovf16_clean", ovf, 0);
        check("t4_sum_w9_held", sum9, 508);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("t4_clear_ovf_w9", ovf9, 0);
        check("t4_clear_busy_w9", busy9, 0);
        check("t4_clear_sum_kept", sum9, 508);

        // Clear after two of four reads; the next block must start from zero
        do_reset();
        push(10); push(20);
        en = 1'b1;
        wait_reads(rd_total + 2, 30);
        b_hs = hs_total;
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("t5_idle_after_clear", busy, 0);
        check("t5_no_sum_valid", sum_valid, 0);
        push(1); push(2); push(3); push(4);
        wait_hs(b_hs + 1, 30);
        check("t5_last_sum", sum_o, 10);
        en = 1'b0;
        tick(2);

        // Randomized traffic
        do_reset();
        for (int unsigned i = 0; i < 1500; i++) begin
            @(negedge Rclk);
            if (n_loaded - n_read < 6) begin
                d = ($urandom % 4 == 0) ? 8'hFF : 8'($urandom_range(0, 255));
                push(d);
            end
            sum_ready = ($urandom % 4) != 0;
            gap_on    = ($urandom % 6) == 0;
            en        = ($urandom % 25) != 0;
            clear     = ($urandom % 150) == 0;
            rrst      = ($urandom % 400) == 0;
        end
        @(negedge Rclk);
        rrst = 1'b0; clear = 1'b0; gap_on = 1'b0; sum_ready = 1'b1; en = 1'b1;
        for (int unsigned i = 0; i < 60; i++) begin
            if (exp_q.size() == 0 && !sum_valid) break;
            @(negedge Rclk);
        end
        check("scoreboard_drained", exp_q.size(), 0);
        en = 1'b0;
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
